serdes_rx_checker: RTL
======================

Name: serdes_rx_checker

Overview:
- Receive-side pattern checker for the CC_SERDES loopback/link bench.
- Consumes the 64-bit decoded RX word and per-byte K flags on the recovered RX clock.
- Hunts for the K28.5 comma lane, verifies the fixed pattern: comma in one byte, filler 0x4A in the other seven.
- Declares lock, then counts pattern errors and drops lock on sustained failure.

Parameters:
COMMA_CHAR, 8'hBC, decoded comma byte; its K flag must be set.
FILL_CHAR, 8'h4A, decoded filler byte; its K flag must be clear.
LOCK_CNT, 16, consecutive good words needed to lock (legal range 2..255).
UNLOCK_CNT, 4, consecutive bad words in LOCKED that force re-hunt (legal range 1..255).
ERR_CNT_W, 32, width of the error counters.

Ports:
RX_CLK_I  in  1  recovered RX clock (RX_CLK_O of the SerDes)
RX_RESET_I  in  1  asynchronous active-high reset
RX_DATA_I  in  64  decoded RX word; byte n = bits [8n+7:8n]
RX_CHAR_IS_K_I  in  8  per-byte K flag
RX_VALID_I  in  1  word qualifier; words with 0 here are ignored entirely
CNT_RESET_I  in  1  synchronous clear of the error counters
LOCKED_O  out  1  high in LOCKED state
STATE_O  out  2  0=HUNT, 1=VERIFY, 2=LOCKED
COMMA_POS_O  out  3  captured comma byte lane
ERR_O  out  1  one-cycle pulse per bad word while LOCKED
ERR_CNT_O  out  ERR_CNT_W  bad-word count, saturating
BIT_ERR_CNT_O  out  ERR_CNT_W  bit-error count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, state HUNT, internal good_cnt=0, bad_cnt=0.
- All outputs are registered. Latency is 1 RX_CLK_I cycle from the input word to the state, ERR_O and counter updates.
- Good word for lane p:
  - byte p == COMMA_CHAR with K[p]=1;
  - every other byte == FILL_CHAR with its K=0.
  - Otherwise the word is bad.
- Candidate word in HUNT: exactly one byte has K=1, that byte equals COMMA_CHAR, and the word is good for that lane.
- HUNT:
  - Valid candidate at lane q: COMMA_POS_O<=q, good_cnt<=1, go to VERIFY.
  - Anything else: stay in HUNT.
- VERIFY:
  - Valid good word for COMMA_POS_O: good_cnt+1. When the new value equals LOCK_CNT, go to LOCKED and set bad_cnt<=0.
  - Valid bad word: good_cnt<=0, go to HUNT. The same word is not re-evaluated as a candidate.
- LOCKED:
  - Valid good word: bad_cnt<=0.
  - Valid bad word: ERR_O=1 for one cycle, ERR_CNT_O+1, bad_cnt+1. When the new bad_cnt equals UNLOCK_CNT, go to HUNT.
  - The unlocking word is still counted and pulses ERR_O.
- Errors are counted only in LOCKED; HUNT and VERIFY never touch the counters or ERR_O.
- Counter saturation: ERR_CNT_O and BIT_ERR_CNT_O hold at all-ones and never wrap.
- CNT_RESET_I:
  - Clears both counters to 0 next cycle.
  - If it coincides with an error, the clear wins: counter = 0, but ERR_O still pulses.
  - Does not affect state, lock or COMMA_POS_O.
- RX_VALID_I=0: no state change, no counter change, ERR_O=0.
- Reset asserted mid-operation returns everything to reset values immediately (async). Deassertion is synchronised externally.
- COMMA_POS_O holds its last captured lane in HUNT.

Optional Feature:
SERDES_RX_CHECKER_BITERR_EN
- Defined: in LOCKED, each valid word adds the popcount of (RX_DATA_I XOR expected word for COMMA_POS_O) to BIT_ERR_CNT_O.
  - Popcount is 0..64 over the 64 data bits; K flags are excluded.
  - Addition saturates at all-ones.
  - Cleared by CNT_RESET_I, with the same clear-wins rule.
- Undefined: BIT_ERR_CNT_O is tied to 0 and no popcount logic is built.

Test Plan:
- Reset, then 20 valid words 0x4A4A4A4A_4A4A4ABC with K=0x01 -> STATE_O 0→1 after word 1, LOCKED_O=1 one cycle after word 16, COMMA_POS_O=0, ERR_CNT_O=0.
- Pattern with comma in lane 5 (0x4A4ABC4A_4A4A4A4A, K=0x20) -> lock with COMMA_POS_O=5. Words with K=0x21 never leave HUNT.
- Locked; inject 3 bad words (byte 2 = 0x4B), then good words -> 3 ERR_O pulses, ERR_CNT_O=3, still locked. Inject 4 consecutive bad words -> STATE_O=0, ERR_CNT_O=7.
- In VERIFY at good_cnt=10, one bad word -> HUNT, then 16 good words are required again to lock.
- RX_VALID_I toggled 0/1 each cycle with the good pattern -> lock after 16 valid words (31 cycles). Invalid cycles carrying garbage cause no errors. CNT_RESET_I coinciding with an error -> ERR_CNT_O=0, ERR_O=1.
- With SERDES_RX_CHECKER_BITERR_EN: locked; one word with bytes 3 and 6 = 0xB5 (8 flipped bits each) -> BIT_ERR_CNT_O=16, ERR_CNT_O=1. Without the macro: BIT_ERR_CNT_O stays 0.

Source files
------------

// File: rtl/serdes_rx_checker.sv
// Receive-side K28.5/filler pattern checker: hunts the comma lane, locks, counts bad words.
// Optional bit-error counting is built when SERDES_RX_CHECKER_BITERR_EN is defined.
`timescale 1ns/1ps

module serdes_rx_checker #(
    parameter logic [7:0]  COMMA_CHAR = 8'hBC,
    parameter logic [7:0]  FILL_CHAR  = 8'h4A,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned UNLOCK_CNT = 4,
    parameter int unsigned ERR_CNT_W  = 32
) (
    input  logic                 RX_CLK_I,
    input  logic                 RX_RESET_I,
    input  logic [63:0]          RX_DATA_I,
    input  logic [7:0]           RX_CHAR_IS_K_I,
    input  logic                 RX_VALID_I,
    input  logic                 CNT_RESET_I,
    output logic                 LOCKED_O,
    output logic [1:0]           STATE_O,
    output logic [2:0]           COMMA_POS_O,
    output logic                 ERR_O,
    output logic [ERR_CNT_W-1:0] ERR_CNT_O,
    output logic [ERR_CNT_W-1:0] BIT_ERR_CNT_O
);

    typedef enum logic [1:0] {StHunt = 2'd0, StVerify = 2'd1, StLocked = 2'd2} state_e;

    localparam logic [7:0] LockCntB   = 8'(LOCK_CNT);
    localparam logic [7:0] UnlockCntB = 8'(UNLOCK_CNT);

    state_e               state_q, state_d;
    logic [7:0]           good_cnt_q, good_cnt_d;
    logic [7:0]           bad_cnt_q, bad_cnt_d;
    logic [2:0]           comma_pos_q, comma_pos_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [7:0] is_comma, is_fill, good_lane;
    logic [2:0] cand_lane;
    logic       good_cur;
    logic [7:0] good_inc, bad_inc;

    // A word good for lane p has K set only at p, so at most one lane can match.
    always_comb begin
        is_comma  = '0;
        is_fill   = '0;
        good_lane = '0;
        cand_lane = '0;
        for (int n = 0; n < 8; n++) begin
            is_comma[n] = (RX_DATA_I[8*n +: 8] == COMMA_CHAR) && RX_CHAR_IS_K_I[n];
            is_fill[n]  = (RX_DATA_I[8*n +: 8] == FILL_CHAR) && !RX_CHAR_IS_K_I[n];
        end
        for (int p = 0; p < 8; p++) begin
            good_lane[p] = is_comma[p] && ((is_fill | (8'd1 << p)) == 8'hFF);
            if (good_lane[p]) cand_lane = 3'(p);
        end
    end

    assign good_cur = good_lane[comma_pos_q];
    assign good_inc = good_cnt_q + 8'd1;
    assign bad_inc  = bad_cnt_q + 8'd1;

    always_ff @(posedge RX_CLK_I or posedge RX_RESET_I) begin
        if (RX_RESET_I) begin
            state_q     <= StHunt;
            good_cnt_q  <= '0;
            bad_cnt_q   <= '0;
            comma_pos_q <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            good_cnt_q  <= good_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            comma_pos_q <= comma_pos_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        comma_pos_d = comma_pos_q;
        err_d       = 1'b0;
        err_cnt_d   = err_cnt_q;
        if (RX_VALID_I) begin
            case (state_q)
                StHunt: begin
                    if (|good_lane) begin
                        comma_pos_d = cand_lane;
                        good_cnt_d  = 8'd1;
                        state_d     = StVerify;
                    end
                end
                StVerify: begin
                    if (good_cur) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LockCntB) begin
                            state_d   = StLocked;
                            bad_cnt_d = '0;
                        end
                    end else begin
                        good_cnt_d = '0;
                        state_d    = StHunt;
                    end
                end
                StLocked: begin
                    if (good_cur) begin
                        bad_cnt_d = '0;
                    end else begin
                        err_d     = 1'b1;
                        err_cnt_d = (&err_cnt_q) ? err_cnt_q : err_cnt_q + ERR_CNT_W'(1);
                        bad_cnt_d = bad_inc;
                        if (bad_inc == UnlockCntB) state_d = StHunt;
                    end
                end
                default: state_d = StHunt;
            endcase
        end
        if (CNT_RESET_I) err_cnt_d = '0;
    end

    always_comb begin
        LOCKED_O    = (state_q == StLocked);
        STATE_O     = state_q;
        COMMA_POS_O = comma_pos_q;
        ERR_O       = err_q;
        ERR_CNT_O   = err_cnt_q;
    end

`ifdef SERDES_RX_CHECKER_BITERR_EN
    logic [ERR_CNT_W-1:0] bit_err_cnt_q, bit_err_cnt_d;
    logic [63:0]          exp_word, diff;
    logic [6:0]           popcnt;
    logic [ERR_CNT_W:0]   bit_sum;

    always_comb begin
        exp_word = '0;
        for (int n = 0; n < 8; n++) begin
            exp_word[8*n +: 8] = (3'(n) == comma_pos_q) ? COMMA_CHAR : FILL_CHAR;
        end
        diff   = RX_DATA_I ^ exp_word;
        popcnt = '0;
        for (int i = 0; i < 64; i++) popcnt = popcnt + 7'(diff[i]);
        bit_sum = {1'b0, bit_err_cnt_q} + (ERR_CNT_W+1)'(popcnt);
        bit_err_cnt_d = bit_err_cnt_q;
        if (RX_VALID_I && state_q == StLocked) begin
            bit_err_cnt_d = bit_sum[ERR_CNT_W] ? '1 : bit_sum[ERR_CNT_W-1:0];
        end
        if (CNT_RESET_I) bit_err_cnt_d = '0;
    end

    always_ff @(posedge RX_CLK_I or posedge RX_RESET_I) begin
        if (RX_RESET_I) bit_err_cnt_q <= '0;
        else            bit_err_cnt_q <= bit_err_cnt_d;
    end

    assign BIT_ERR_CNT_O = bit_err_cnt_q;
`else
    assign BIT_ERR_CNT_O = '0;
`endif

endmodule
